// File: rtl/avalon_timer_driver.sv
// Avalon-MM master that programs the interval timer, services its timeout irq and takes counter snapshots.
// Optional: define TIMER_DRV_STATUS_CHECK_EN to read status before clearing and count spurious irqs.
`timescale 1ns/1ps
module avalon_timer_driver #(
    parameter logic [31:0] DEF_PERIOD = 32'd24999999,
    parameter logic [3:0]  CTRL_RUN   = 4'h7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        snap_req_i,
    input  logic [31:0] cfg_period_i,
    input  logic        timer_irq_i,
    output logic        busy_o,
    output logic        tick_o,
    output logic [31:0] tick_count_o,
    output logic [31:0] snap_value_o,
    output logic        snap_valid_o,
`ifdef TIMER_DRV_STATUS_CHECK_EN
    output logic [15:0] spurious_count_o,
`endif
    output logic [2:0]  avm_address_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [15:0] avm_writedata_o,
    input  logic [15:0] avm_readdata_i,
    input  logic        avm_waitrequest_i,
    input  logic        avm_readdatavalid_i
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, WR_CLR, WR_SNAP,
        RD_SL, WAIT_SL, RD_SH, WAIT_SH, WR_STOP, RD_ST, WAIT_ST
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic [15:0] snap_lo_q, snap_lo_d;
    logic        tick_q, tick_d;
    logic        snap_valid_q, snap_valid_d;
    logic        stop_pend_q, stop_pend_d;
    logic        snap_pend_q, snap_pend_d;
    logic        busy_q;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rd_q, rd_d, wr_q, wr_d;
`ifdef TIMER_DRV_STATUS_CHECK_EN
    logic [15:0] spur_q, spur_d;
`endif

    logic wr_done, rd_done, rdv, stop_eff, snap_eff;
    assign wr_done  = wr_q && !avm_waitrequest_i;
    assign rd_done  = rd_q && !avm_waitrequest_i;
    assign rdv      = avm_readdatavalid_i;
    // Include a pulse arriving this very cycle so a simultaneous stop beats the irq.
    assign stop_eff = stop_pend_q | stop_i;
    assign snap_eff = snap_pend_q | snap_req_i;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        tick_count_d = tick_count_q;
        snap_value_d = snap_value_q;
        snap_lo_d    = snap_lo_q;
        tick_d       = 1'b0;
        snap_valid_d = 1'b0;
        stop_pend_d  = stop_pend_q | ((state_q != IDLE) && stop_i);
        snap_pend_d  = snap_pend_q | ((state_q != IDLE) && snap_req_i);
`ifdef TIMER_DRV_STATUS_CHECK_EN
        spur_d       = spur_q;
`endif
        unique case (state_q)
            IDLE: if (start_i) begin
                period_d = (cfg_period_i == 32'd0) ? DEF_PERIOD : cfg_period_i;
                state_d  = WR_PL;
            end
            WR_PL:   if (wr_done) state_d = WR_PH;
            WR_PH:   if (wr_done) state_d = WR_CTRL;
            WR_CTRL: if (wr_done) state_d = RUN;
            RUN: begin
                if (stop_eff)
                    state_d = WR_STOP;
                else if (timer_irq_i)
`ifdef TIMER_DRV_STATUS_CHECK_EN
                    state_d = RD_ST;
`else
                    state_d = WR_CLR;
`endif
                else if (snap_eff)
                    state_d = WR_SNAP;
            end
            WR_CLR: if (wr_done) begin
                tick_d       = 1'b1;
                tick_count_d = tick_count_q + 32'd1;
                state_d      = RUN;
            end
            WR_SNAP: if (wr_done) state_d = RD_SL;
            RD_SL:   if (rd_done) state_d = WAIT_SL;
            WAIT_SL: if (rdv) begin
                snap_lo_d = avm_readdata_i;
                state_d   = RD_SH;
            end
            RD_SH:   if (rd_done) state_d = WAIT_SH;
            WAIT_SH: if (rdv) begin
                snap_value_d = {avm_readdata_i, snap_lo_q};
                snap_valid_d = 1'b1;
                snap_pend_d  = 1'b0;
                state_d      = RUN;
            end
            WR_STOP: if (wr_done) begin
                stop_pend_d = 1'b0;
                snap_pend_d = 1'b0;
                state_d     = IDLE;
            end
`ifdef TIMER_DRV_STATUS_CHECK_EN
            RD_ST:   if (rd_done) state_d = WAIT_ST;
            WAIT_ST: if (rdv) begin
                if (avm_readdata_i[0]) begin
                    state_d = WR_CLR;
                end else begin
                    if (spur_q != 16'hFFFF) spur_d = spur_q + 16'd1;
                    state_d = RUN;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are a pure function of the next state, so they stay frozen while stalled.
    always_comb begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        unique case (state_d)
            WR_PL:   begin wr_d = 1'b1; addr_d = 3'd2; wdata_d = period_d[15:0];  end
            WR_PH:   begin wr_d = 1'b1; addr_d = 3'd3; wdata_d = period_d[31:16]; end
            WR_CTRL: begin wr_d = 1'b1; addr_d = 3'd1; wdata_d = {12'h000, CTRL_RUN}; end
            WR_CLR:  begin wr_d = 1'b1; addr_d = 3'd0; end
            WR_SNAP: begin wr_d = 1'b1; addr_d = 3'd4; end
            RD_SL:   begin rd_d = 1'b1; addr_d = 3'd4; end
            RD_SH:   begin rd_d = 1'b1; addr_d = 3'd5; end
            WR_STOP: begin wr_d = 1'b1; addr_d = 3'd1; wdata_d = 16'h0008; end
            RD_ST:   begin rd_d = 1'b1; addr_d = 3'd0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= 32'd0;
            tick_count_q <= 32'd0;
            snap_value_q <= 32'd0;
            snap_lo_q    <= 16'd0;
            tick_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= 3'd0;
            wdata_q      <= 16'd0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
`ifdef TIMER_DRV_STATUS_CHECK_EN
            spur_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            tick_count_q <= tick_count_d;
            snap_value_q <= snap_value_d;
            snap_lo_q    <= snap_lo_d;
            tick_q       <= tick_d;
            snap_valid_q <= snap_valid_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            busy_q       <= (state_d != IDLE);
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
`ifdef TIMER_DRV_STATUS_CHECK_EN
            spur_q       <= spur_d;
`endif
        end
    end

    assign busy_o          = busy_q;
    assign tick_o          = tick_q;
    assign tick_count_o    = tick_count_q;
    assign snap_value_o    = snap_value_q;
    assign snap_valid_o    = snap_valid_q;
    assign avm_address_o   = addr_q;
    assign avm_read_o      = rd_q;
    assign avm_write_o     = wr_q;
    assign avm_writedata_o = wdata_q;
`ifdef TIMER_DRV_STATUS_CHECK_EN
    assign spurious_count_o = spur_q;
`endif

endmodule

// File: tb/tb_avalon_timer_driver.sv
// Scoreboard bench for avalon_timer_driver: a timer-slave model checks every bus transfer,
// tick and snapshot against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_avalon_timer_driver;
    localparam logic [31:0] DEF = 32'h017D_783F;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, snap_req = 1'b0, timer_irq = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic        busy, tick, snap_valid, avm_read, avm_write;
    logic [31:0] tick_count, snap_value;
    logic [2:0]  avm_address;
    logic [15:0] avm_writedata;
    logic [15:0] readdata = 16'h0000;
    logic        waitreq = 1'b0, rdv = 1'b0;
`ifdef TIMER_DRV_STATUS_CHECK_EN
    logic [15:0] spurious_count;
`endif

    avalon_timer_driver dut (
        .clk(clk), .reset_n(reset_n), .start_i(start), .stop_i(stop), .snap_req_i(snap_req),
        .cfg_period_i(cfg_period), .timer_irq_i(timer_irq), .busy_o(busy), .tick_o(tick),
        .tick_count_o(tick_count), .snap_value_o(snap_value), .snap_valid_o(snap_valid),
`ifdef TIMER_DRV_STATUS_CHECK_EN
        .spurious_count_o(spurious_count),
`endif
        .avm_address_o(avm_address), .avm_read_o(avm_read), .avm_write_o(avm_write),
        .avm_writedata_o(avm_writedata), .avm_readdata_i(readdata),
        .avm_waitrequest_i(waitreq), .avm_readdatavalid_i(rdv));

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [2:0] addr; logic [15:0] data; } xfer_t;
    xfer_t       exp_bus[$];
    logic [31:0] exp_tick[$];
    logic [31:0] exp_snap[$];
    logic [15:0] rd_data_q[$];
    int          acc_cyc[$];

    int errors = 0, checks = 0, cyc = 0;
    int wmode = 0;        // 0 no stall, 1 random stall, 2 stall forever
    int stall_ph = 0;     // stall cycles to apply to the period-high write
    int fixed_lat = -1;   // readdatavalid latency, -1 = random
    int s_cyc = 0;
    logic [31:0] model_ticks = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event addr=%0d wr=%0b data=%h (t=%0t)",
                 name, avm_address, avm_write, avm_writedata, $time);
    endtask

    // Timer slave model plus monitor: decoupled from the stimulus via the queues.
    initial begin : slave
        logic        prev_hold, rd_pending;
        logic [21:0] prev_bus;
        int          rd_cnt;
        xfer_t       e;
        prev_hold = 1'b0; rd_pending = 1'b0; rd_cnt = 0; prev_bus = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_hold = 1'b0;
                rd_pending = 1'b0;
            end else begin
                if (prev_hold)
                    chk("bus_hold", {10'd0, avm_read, avm_write, avm_address, avm_writedata},
                        {10'd0, prev_bus});
                if (avm_read || avm_write)
                    chk("one_strobe", {31'd0, avm_read & avm_write}, 32'd0);
                prev_hold = (avm_read || avm_write) && waitreq;
                prev_bus  = {avm_read, avm_write, avm_address, avm_writedata};
                if ((avm_read || avm_write) && !waitreq) begin
                    acc_cyc.push_back(cyc);
                    if (exp_bus.size() == 0) unexpected("xfer");
                    else begin
                        e = exp_bus.pop_front();
                        chk("xfer", {12'd0, avm_write, avm_address, avm_write ? avm_writedata : 16'h0},
                            {12'd0, e.wr, e.addr, e.data});
                    end
                    if (avm_read) begin
                        rd_pending = 1'b1;
                        rd_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
                    end
                end
                if (tick) begin
                    if (exp_tick.size() == 0) unexpected("tick");
                    else chk("tick_count", tick_count, exp_tick.pop_front());
                end
                if (snap_valid) begin
                    if (exp_snap.size() == 0) unexpected("snap_valid");
                    else chk("snap_value", snap_value, exp_snap.pop_front());
                end
            end
            @(posedge clk); #1;
            rdv = 1'b0;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    rdv = 1'b1;
                    readdata = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 16'hDEAD;
                    rd_pending = 1'b0;
                end else rd_cnt--;
            end
            if (wmode == 2) waitreq = 1'b1;
            else if (stall_ph > 0 && avm_write && avm_address == 3'd3) begin
                waitreq = 1'b1;
                stall_ph--;
            end else if (wmode == 1) waitreq = ($urandom_range(0, 2) == 0);
            else waitreq = 1'b0;
        end
    end

    function automatic xfer_t mk(input logic wr, input logic [2:0] a, input logic [15:0] d);
        xfer_t x;
        x.wr = wr; x.addr = a; x.data = d;
        return x;
    endfunction

    task automatic wait_bus(input int left, input string name);
        int n = 0;
        while (exp_bus.size() > left && n < 300) begin @(posedge clk); #2; n++; end
        if (n >= 300) unexpected({name, "_timeout"});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_bus.size() || exp_tick.size() || exp_snap.size()) && n < 300) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 300) unexpected({name, "_timeout"});
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [31:0] p);
        logic [31:0] pe;
        pe = (p == 32'd0) ? DEF : p;
        exp_bus.push_back(mk(1'b1, 3'd2, pe[15:0]));
        exp_bus.push_back(mk(1'b1, 3'd3, pe[31:16]));
        exp_bus.push_back(mk(1'b1, 3'd1, 16'h0007));
        @(posedge clk); #2;
        cfg_period = p; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; s_cyc = cyc;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic push_irq();
`ifdef TIMER_DRV_STATUS_CHECK_EN
        exp_bus.push_back(mk(1'b0, 3'd0, 16'h0));
        rd_data_q.push_back(16'h0001);
`endif
        exp_bus.push_back(mk(1'b1, 3'd0, 16'h0000));
        model_ticks = model_ticks + 32'd1;
        exp_tick.push_back(model_ticks);
    endtask

    task automatic push_snap(input logic [15:0] lo, input logic [15:0] hi);
        exp_bus.push_back(mk(1'b1, 3'd4, 16'h0000));
        exp_bus.push_back(mk(1'b0, 3'd4, 16'h0));
        exp_bus.push_back(mk(1'b0, 3'd5, 16'h0));
        rd_data_q.push_back(lo);
        rd_data_q.push_back(hi);
        exp_snap.push_back({hi, lo});
    endtask

    // irq held until its clear write is accepted, optionally with a simultaneous snap_req.
    task automatic do_irq(input logic with_snap, input logic [15:0] lo, input logic [15:0] hi);
        push_irq();
        if (with_snap) push_snap(lo, hi);
        @(posedge clk); #2;
        timer_irq = 1'b1;
        if (with_snap) snap_req = 1'b1;
        @(posedge clk); #2;
        snap_req = 1'b0;
        wait_bus(with_snap ? 3 : 0, "irq");
        timer_irq = 1'b0;
        drain("irq");
    endtask

    task automatic do_snap(input logic [15:0] lo, input logic [15:0] hi);
        push_snap(lo, hi);
        @(posedge clk); #2; snap_req = 1'b1;
        @(posedge clk); #2; snap_req = 1'b0;
        drain("snap");
    endtask

    task automatic do_stop(input logic with_irq);
        exp_bus.push_back(mk(1'b1, 3'd1, 16'h0008));
        @(posedge clk); #2;
        stop = 1'b1; timer_irq = with_irq;
        @(posedge clk); #2;
        stop = 1'b0;
        @(posedge clk); #2;
        timer_irq = 1'b0;
        drain("stop");
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("tick_count_after_stop", tick_count, model_ticks);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int op;
        logic [15:0] lo, hi;
        logic [31:0] p;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write", {30'd0, avm_write, avm_read}, 32'd0);
        chk("rst_tick_count", tick_count, 32'd0);
        chk("rst_pulses", {30'd0, tick, snap_valid}, 32'd0);
        chk("rst_snap_value", snap_value, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // zero-wait startup timing
        acc_cyc.delete();
        do_start(32'h0001_86A0);
        drain("start1");
        chk("first_write_edge", acc_cyc[0] - s_cyc, 32'd0);
        chk("write_gap_1", acc_cyc[1] - acc_cyc[0], 32'd1);
        chk("write_gap_2", acc_cyc[2] - acc_cyc[1], 32'd1);

        // five irq services
        repeat (5) do_irq(1'b0, 16'h0, 16'h0);
        chk("tick_count_5", tick_count, 32'd5);

        // directed snapshot
        fixed_lat = 1;
        do_snap(16'h1234, 16'h00AB);
        chk("snap_directed", snap_value, 32'h00AB_1234);
        fixed_lat = -1;

        // stop beats simultaneous irq, then default period
        do_stop(1'b1);
        do_start(32'd0);
        drain("start_def");

        // stalled period-high write
        do_stop(1'b0);
        stall_ph = 3;
        do_start(32'hCAFE_0042);
        drain("start_stall");
        chk("stall_consumed", stall_ph, 32'd0);

        // randomized traffic with random stalls and read latency
        wmode = 1;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 4);
            lo = 16'($urandom); hi = 16'($urandom);
            case (op)
                0, 1: do_irq(1'b0, 16'h0, 16'h0);
                2:    do_snap(lo, hi);
                3:    do_irq(1'b1, lo, hi);
                default: begin
                    do_stop(1'($urandom_range(0, 1)));
                    p = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    do_start(p);
                    drain("rand_start");
                end
            endcase
        end
        chk("tick_count_random", tick_count, model_ticks);

        // reset while a write is stalled
        wmode = 0;
        do_stop(1'b0);
        wmode = 2;
        do_start(32'h0000_1000);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_write", {31'd0, avm_write}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_write_drop", {30'd0, avm_write, avm_read}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_tick_count", tick_count, 32'd0);
        exp_bus.delete(); exp_tick.delete(); exp_snap.delete(); rd_data_q.delete();
        model_ticks = 32'd0;
        wmode = 0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("idle_after_reset", {30'd0, busy, avm_write}, 32'd0);
        do_start(32'h0000_0010);
        drain("restart");
        do_irq(1'b0, 16'h0, 16'h0);
        chk("tick_after_reset", tick_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
